// File: rtl/fib_checker.sv
// Self-test consumer for the 16-bit Fibonacci generator: requests terms, checks
// each against a locally computed sequence, and reports pass, mismatch or timeout.
module fib_checker #(
    parameter int          MAX_TERMS = 25,
    parameter int unsigned TIMEOUT   = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f_valid,
    input  logic [15:0] f_out,
    output logic        f_en,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        error,
    output logic        timeout,
    output logic [4:0]  term_cnt,
    output logic [15:0] last_value,
    output logic [15:0] err_value
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_exp_a;
    logic [15:0] r_exp_b;
    logic [31:0] r_to_cnt;
    logic [4:0]  r_term_cnt;
    logic [15:0] r_last_value;
    logic [15:0] r_err_value;
    logic        r_pass;
    logic        r_error;
    logic        r_timeout;
    logic        w_start_ok;
    logic        w_match;
    logic        w_last;
    logic        w_expire;

    // Next expected term; wraps to 16 bits, which only happens past the last checked term.
    function automatic logic [15:0] fib_next(input logic [15:0] a, input logic [15:0] b);
        return a + b;
    endfunction

    assign w_start_ok = start && (r_state != S_RUN);
    assign w_match    = (f_out == r_exp_a);
    assign w_last     = ((r_term_cnt + 5'd1) == 5'(MAX_TERMS));
    assign w_expire   = !f_valid && (r_to_cnt == 32'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (f_valid) begin
                    if (!w_match || w_last) begin
                        w_next = S_DONE;
                    end
                end else if (w_expire) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp_a      <= '0;
            r_exp_b      <= '0;
            r_to_cnt     <= '0;
            r_term_cnt   <= '0;
            r_last_value <= '0;
            r_err_value  <= '0;
            r_pass       <= 1'b0;
            r_error      <= 1'b0;
            r_timeout    <= 1'b0;
        end else if (w_start_ok) begin
            r_exp_a      <= 16'd0;
            r_exp_b      <= 16'd1;
            r_to_cnt     <= '0;
            r_term_cnt   <= '0;
            r_last_value <= '0;
            r_err_value  <= '0;
            r_pass       <= 1'b0;
            r_error      <= 1'b0;
            r_timeout    <= 1'b0;
        end else if (r_state == S_RUN) begin
            // A strobe on the expiry cycle takes priority over the timeout.
            if (f_valid) begin
                if (w_match) begin
                    r_exp_a      <= r_exp_b;
                    r_exp_b      <= fib_next(r_exp_a, r_exp_b);
                    r_last_value <= f_out;
                    r_term_cnt   <= r_term_cnt + 5'd1;
                    r_to_cnt     <= '0;
                    if (w_last) begin
                        r_pass <= 1'b1;
                    end
                end else begin
                    r_error     <= 1'b1;
                    r_err_value <= f_out;
                end
            end else if (w_expire) begin
                r_timeout <= 1'b1;
            end else begin
                r_to_cnt <= r_to_cnt + 32'd1;
            end
        end
    end

    assign f_en       = (r_state == S_RUN);
    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign pass       = r_pass;
    assign error      = r_error;
    assign timeout    = r_timeout;
    assign term_cnt   = r_term_cnt;
    assign last_value = r_last_value;
    assign err_value  = r_err_value;

endmodule

// File: tb/tb_fib_checker.sv
// Directed bench for fib_checker: table of whole runs plus hand-written
// sequences for timeout, reset, start-in-RUN and a two-term configuration.
module tb_fib_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, f_valid;
    logic [15:0] f_out;
    logic        f_en, busy, done, pass, error, timeout;
    logic [4:0]  term_cnt;
    logic [15:0] last_value, err_value;

    logic        start2, f_valid2;
    logic [15:0] f_out2;
    logic        f_en2, busy2, done2, pass2, error2, timeout2;
    logic [4:0]  term_cnt2;
    logic [15:0] last_value2, err_value2;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] fib [25];

    typedef struct {
        int          gap;
        int          cidx;
        logic [15:0] cval;
        logic        exp_pass;
        logic        exp_error;
        logic [4:0]  exp_cnt;
        logic [15:0] exp_last;
        logic [15:0] exp_err;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    fib_checker #(.MAX_TERMS(25), .TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .f_valid(f_valid), .f_out(f_out),
        .f_en(f_en), .busy(busy), .done(done), .pass(pass), .error(error),
        .timeout(timeout), .term_cnt(term_cnt), .last_value(last_value),
        .err_value(err_value)
    );

    fib_checker #(.MAX_TERMS(2), .TIMEOUT(16)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .f_valid(f_valid2), .f_out(f_out2),
        .f_en(f_en2), .busy(busy2), .done(done2), .pass(pass2), .error(error2),
        .timeout(timeout2), .term_cnt(term_cnt2), .last_value(last_value2),
        .err_value(err_value2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] v);
        f_valid = 1'b1;
        f_out   = v;
        tick();
        f_valid = 1'b0;
        f_out   = 16'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " f_en"}, 32'(f_en), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " pass"}, 32'(pass), 0);
        check({tag, " error"}, 32'(error), 0);
        check({tag, " timeout"}, 32'(timeout), 0);
        check({tag, " term_cnt"}, 32'(term_cnt), 0);
        check({tag, " last_value"}, 32'(last_value), 0);
        check({tag, " err_value"}, 32'(err_value), 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        do_start();
        check({tag, " busy after start"}, 32'(busy), 1);
        check({tag, " cleared term_cnt"}, 32'(term_cnt), 0);
        for (int i = 0; i < 25; i++) begin
            repeat (v.gap - 1) tick();
            strobe((i == v.cidx) ? v.cval : fib[i]);
            if (done) break;
        end
        check({tag, " f_en after final strobe"}, 32'(f_en), 0);
        // Strobes while DONE must leave the result untouched.
        strobe(fib[0]);
        strobe(fib[1]);
        check({tag, " done"}, 32'(done), 1);
        check({tag, " pass"}, 32'(pass), 32'(v.exp_pass));
        check({tag, " error"}, 32'(error), 32'(v.exp_error));
        check({tag, " timeout"}, 32'(timeout), 0);
        check({tag, " term_cnt"}, 32'(term_cnt), 32'(v.exp_cnt));
        check({tag, " last_value"}, 32'(last_value), 32'(v.exp_last));
        check({tag, " err_value"}, 32'(err_value), 32'(v.exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        fib[0] = 16'd0;
        fib[1] = 16'd1;
        for (int i = 2; i < 25; i++) fib[i] = fib[i-1] + fib[i-2];

        vecs[0] = '{4,  -1, 16'd0,     1'b1, 1'b0, 5'd25, 16'd46368, 16'd0};
        vecs[1] = '{4,   5, 16'd6,     1'b0, 1'b1, 5'd5,  16'd3,     16'd6};
        vecs[2] = '{1,   0, 16'd1,     1'b0, 1'b1, 5'd0,  16'd0,     16'd1};
        vecs[3] = '{1,  -1, 16'd0,     1'b1, 1'b0, 5'd25, 16'd46368, 16'd0};
        vecs[4] = '{2,  24, 16'd46367, 1'b0, 1'b1, 5'd24, 16'd28657, 16'd46367};

        rst = 1'b1; start = 1'b0; f_valid = 1'b0; f_out = 16'd0;
        start2 = 1'b0; f_valid2 = 1'b0; f_out2 = 16'd0;
        tick();
        tick();
        check_all_zero("reset");
        check("reset dut2 done", 32'(done2), 0);
        rst = 1'b0;

        // f_valid in IDLE is ignored
        strobe(16'd0);
        strobe(16'd5);
        check_all_zero("idle strobes");

        for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

        // Timeout with no strobes: done exactly TIMEOUT cycles after f_en rises
        do_start();
        cyc = 0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        check("timeout latency", 32'(cyc), 16);
        check("timeout flag", 32'(timeout), 1);
        check("timeout pass", 32'(pass), 0);
        check("timeout error", 32'(error), 0);
        check("timeout f_en", 32'(f_en), 0);

        // Strobe on the expiry cycle is accepted and restarts the counter
        do_start();
        repeat (15) tick();
        strobe(16'd0);
        check("expiry strobe done", 32'(done), 0);
        check("expiry strobe timeout", 32'(timeout), 0);
        check("expiry strobe term_cnt", 32'(term_cnt), 1);
        repeat (15) tick();
        check("restarted counter not expired", 32'(done), 0);
        tick();
        check("restarted counter expired", 32'(timeout), 1);
        check("restarted counter term_cnt", 32'(term_cnt), 1);

        // Reset mid-run after 7 terms
        do_start();
        for (int i = 0; i < 7; i++) strobe(fib[i]);
        check("pre-reset term_cnt", 32'(term_cnt), 7);
        check("pre-reset last_value", 32'(last_value), 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("mid-run reset");
        run_vec(vecs[0], 10);

        // start during RUN is ignored
        do_start();
        for (int i = 0; i < 3; i++) strobe(fib[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start in RUN busy", 32'(busy), 1);
        check("start in RUN term_cnt", 32'(term_cnt), 3);
        for (int i = 3; i < 25; i++) strobe(fib[i]);
        check("start in RUN pass", 32'(pass), 1);
        check("start in RUN final term_cnt", 32'(term_cnt), 25);

        // Two-term configuration
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        f_valid2 = 1'b1; f_out2 = 16'd0;
        tick();
        check("dut2 mid-run done", 32'(done2), 0);
        f_out2 = 16'd1;
        tick();
        f_valid2 = 1'b0; f_out2 = 16'd0;
        check("dut2 done", 32'(done2), 1);
        check("dut2 pass", 32'(pass2), 1);
        check("dut2 term_cnt", 32'(term_cnt2), 2);
        check("dut2 last_value", 32'(last_value2), 1);
        check("dut2 f_en", 32'(f_en2), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fib_checker.md
# fib_checker

Consumer-side checker for the 16-bit Fibonacci stream produced by the team's `fibonacci` generator. It drives the generator's `f_en` request and samples `f_valid`/`f_out`. Each received term is compared against an internally computed expected sequence 0, 1, 1, 2, 3, … The block reports pass, mismatch or timeout, and sits on the board next to the generator as its self-test and status source.

## Interface

- `MAX_TERMS`, 25: number of terms checked per run; legal range 2..25 (term 24 = 46368 is the last that fits in 16 bits).
- `TIMEOUT`, 10_000_000: consecutive RUN cycles without `f_valid` that abort the run; legal range 2..2^32-1.
- `clk`  in  1  system clock; the single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- `f_valid`  in  1  one-cycle strobe from the generator; `f_out` is valid on the same cycle.
- `f_out`  in  16  current Fibonacci term from the generator.
- `f_en`  out  1  enable to the generator; high exactly while in RUN.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE; held until `start` or `rst`.
- `pass`  out  1  valid with `done`: all `MAX_TERMS` terms matched.
- `error`  out  1  valid with `done`: a term mismatched.
- `timeout`  out  1  valid with `done`: `TIMEOUT` expired.
- `term_cnt`  out  5  number of terms accepted as correct in the current/last run.
- `last_value`  out  16  last correctly received term.
- `err_value`  out  16  offending `f_out` on mismatch; 0 otherwise.

## Operation

- The FSM has three states: IDLE, RUN and DONE.
- IDLE → RUN on `start`.
  - The same edge clears `term_cnt`, `last_value`, `err_value`, `pass`, `error`, `timeout` and the timeout counter.
  - It also loads the expected registers `exp_a`=0 and `exp_b`=1.
- DONE → RUN on `start`, with the same clears and loads as from IDLE.
- `start` in RUN is ignored.
- In RUN, on an `f_valid` cycle, compare `f_out` with `exp_a`.
  - **Match:**
    - `exp_a`←`exp_b` and `exp_b`←(`exp_a`+`exp_b`). The sum is computed 17-bit and truncated to 16 bits. The truncated values only occur after the final term and are never compared.
    - `last_value`←`f_out`, `term_cnt`←`term_cnt`+1, timeout counter←0.
    - If the new `term_cnt` equals `MAX_TERMS`: → DONE, `pass`=1.
  - **Mismatch:** → DONE, `error`=1, `err_value`←`f_out`. `term_cnt` and `last_value` are unchanged.
- In RUN, on a cycle without `f_valid`, the timeout counter increments. When it reaches `TIMEOUT`-1 on a cycle without `f_valid`: → DONE, `timeout`=1.
- If `f_valid` arrives on the cycle the counter would expire, `f_valid` wins: the term is checked and the counter is cleared.
- `f_valid` in IDLE or DONE is ignored; there are no state or register changes.
- Exactly one of `pass`/`error`/`timeout` is set in DONE.

## Timing

- Reset values on the next `clk` edge with `rst`=1: state=IDLE, and all outputs and internal registers are 0. This includes `f_en`, `busy`, `done`, `pass`, `error`, `timeout`, `term_cnt`, `last_value` and `err_value`.
- `rst` mid-run aborts immediately: `f_en` is 0 on the cycle after the reset edge, and no partial result is kept.
- `start` sampled high at edge N: `f_en`=`busy`=1 from cycle N+1.
- Final matching `f_valid` at edge N: `done`=1, `pass`=1 and `f_en`=0 from N+1. `term_cnt` and `last_value` update at the same edge.
- Mismatch at edge N: `done`=1, `error`=1, `err_value` valid and `f_en`=0 from N+1.
- Timeout: with no `f_valid` since the RUN entry or the last accepted term, `done`/`timeout` rise `TIMEOUT` cycles after that point.
- The comparison is combinational from `f_out`/`exp_a` into the registered decision. Latency is 1 cycle per term, and back-to-back `f_valid` on consecutive cycles is supported.
- `start` asserted in DONE restarts the run with a one-cycle turnaround.

## Test plan

- Ideal producer, `MAX_TERMS`=25, `f_valid` every 4 cycles. Required response:
  - `done`=1, `pass`=1, `term_cnt`=25, `last_value`=46368.
  - `f_en` low the cycle after the 25th strobe.
- Corrupt term index 5 (send 6 instead of 5). Required response:
  - `done`=1, `error`=1, `err_value`=6, `term_cnt`=5, `last_value`=3.
  - Later strobes are ignored.
- `TIMEOUT`=16 with `start` and no `f_valid`: `done`=1 and `timeout`=1 exactly 16 cycles after `f_en` rises.
- `TIMEOUT`=16 with a strobe on the expiry cycle: the term is accepted, `timeout` stays 0, and the counter restarts.
- `rst` asserted after 7 terms. Required response:
  - On the next cycle, all outputs are 0 and state is IDLE.
  - A subsequent `start` with the ideal producer gives `pass`=1.
- Mixed stimulus:
  - `f_valid` pulses in IDLE change nothing.
  - `start` pulses during RUN change nothing.
  - `MAX_TERMS`=2 run with 0, 1 → `pass`=1, `term_cnt`=2.
